// File: rtl/scan_ctrl_pkg.sv
// Shared types and helpers for the scan chain controller: FSM state encoding
// and a ceiling-log2 used to size the shift counter.
package scan_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   // Ceiling log2, never below 1 so a one-bit chain still gets a counter bit.
   function automatic int clog2(input int value);
      int bits;
      bits = 0;
      while ((1 << bits) < value) bits++;
      return (bits < 1) ? 1 : bits;
   endfunction

endpackage

// File: rtl/scan_cell.sv
// One mux-D scan cell: se picks scan-in over functional data, hold freezes the
// bit, and the flop clears asynchronously.
module scan_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   input  logic si,
   input  logic se,
   input  logic hold,
   output logic q
);

   // NOTE: sequential state is written with <= only, so every flop in the
   // chain samples its neighbour's pre-edge value and the shift moves one place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= 1'b0;
      else if (!hold)
         q <= se ? si : d;
   end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Multi-chain scan register with its own shift/capture sequencer; sits between
// the functional logic (d/q) and the tester scan pins (si/so).
module scan_chain_ctrl
   import scan_ctrl_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int CHAINS = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  d,
   input  logic              func_en,
   input  logic              test_start,
   input  logic [CHAINS-1:0] si,
   output logic [CHAINS-1:0] so,
   output logic [WIDTH-1:0]  q,
   output logic              scan_en,
   output logic              busy,
   output logic              done
);

   localparam int CHAIN_LEN = WIDTH / CHAINS;
   localparam int CNT_W     = clog2(CHAIN_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

   if ((WIDTH % CHAINS) != 0) begin : g_bad_width
      $error("scan_chain_ctrl: WIDTH must be a multiple of CHAINS");
   end

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             se, hold;

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      se         = 1'b0;
      hold       = 1'b1;
      case (state)
         IDLE: begin
            if (test_start) begin
               state_next = SHIFT;
               cnt_next   = '0;
            end else if (func_en) begin
               hold = 1'b0;
            end
         end
         SHIFT: begin
            se       = 1'b1;
            hold     = 1'b0;
            cnt_next = cnt + CNT_W'(1);
            if (cnt == CNT_LAST) state_next = CAPTURE;
         end
         CAPTURE: begin
            hold       = 1'b0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         done  <= (state == CAPTURE);
      end
   end

   assign scan_en = (state == SHIFT);
   assign busy    = (state != IDLE);

   // Each chain shifts toward its LSB; the chain's top cell takes si[c].
   for (genvar c = 0; c < CHAINS; c++) begin : g_chain
      for (genvar b = 0; b < CHAIN_LEN; b++) begin : g_bit
         logic cell_si;
         if (b == CHAIN_LEN - 1) begin : g_top
            assign cell_si = si[c];
         end else begin : g_mid
            assign cell_si = q[c*CHAIN_LEN + b + 1];
         end
         scan_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (d[c*CHAIN_LEN + b]),
            .si    (cell_si),
            .se    (se),
            .hold  (hold),
            .q     (q[c*CHAIN_LEN + b])
         );
      end
      assign so[c] = q[c*CHAIN_LEN];
   end

endmodule
